// File: rtl/calc_pkg.sv
// Shared widths, command encoding and request record for the calculator front end.
package calc_pkg;
  localparam int REQ_CMD_WIDTH  = 4;
  localparam int REQ_DATA_WIDTH = 32;
  localparam int REQ_TAG_WIDTH  = 2;
  localparam int OUT_RESP_WIDTH = 32;

  typedef enum logic [REQ_CMD_WIDTH-1:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } calc_cmd_e;

  // cmd kept as raw bits: any nonzero code is forwarded unchecked
  typedef struct packed {
    logic [REQ_CMD_WIDTH-1:0]  cmd;
    logic [REQ_TAG_WIDTH-1:0]  tag;
    logic [REQ_DATA_WIDTH-1:0] op1;
    logic [REQ_DATA_WIDTH-1:0] op2;
  } calc_req_t;
endpackage

// File: rtl/calc_port_fifo.sv
// One request port: two-cycle capture FSM feeding a small in-order FIFO,
// with a one-cycle overflow pulse when a completed request finds it full.
module calc_port_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic [REQ_CMD_WIDTH-1:0]  i_cmd,
  input  logic [REQ_DATA_WIDTH-1:0] i_data,
  input  logic [REQ_TAG_WIDTH-1:0]  i_tag,
  input  logic                      i_pop,
  output logic                      o_empty,
  output calc_req_t                 o_head,
  output logic                      o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_OP2} cap_st_e;

  cap_st_e                   r_st, w_st_nxt;
  logic                      w_latch, w_push, w_do_push, w_do_pop;
  logic [REQ_CMD_WIDTH-1:0]  r_cmd;
  logic [REQ_TAG_WIDTH-1:0]  r_tag;
  logic [REQ_DATA_WIDTH-1:0] r_op1;
  logic [AW-1:0]             r_wr, r_rd;
  logic [AW:0]               r_cnt;
  logic                      r_ovf;
  calc_req_t                 r_mem [DEPTH];

  always_comb begin
    w_st_nxt = r_st;
    w_latch  = 1'b0;
    w_push   = 1'b0;
    case (r_st)
      S_IDLE: if (i_cmd != '0) begin
        w_latch  = 1'b1;
        w_st_nxt = S_OP2;
      end
      S_OP2: begin
        w_push   = 1'b1;
        w_st_nxt = S_IDLE;
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_do_pop  = i_pop && (r_cnt != '0);
  assign w_do_push = w_push && ((r_cnt != CNT_FULL) || w_do_pop);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_st  <= S_IDLE;
      r_cmd <= '0;
      r_tag <= '0;
      r_op1 <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_ovf <= w_push && !w_do_push;
      if (w_latch) begin
        r_cmd <= i_cmd;
        r_tag <= i_tag;
        r_op1 <= i_data;
      end
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge gclk) begin
    if (w_do_push) r_mem[r_wr] <= '{cmd: r_cmd, tag: r_tag, op1: r_op1, op2: i_data};
  end

  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/calc_req_front.sv
// Calculator request front end: per-port capture/FIFO plus a round-robin
// arbiter onto a single valid/ready issue channel.
module calc_req_front
  import calc_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     ifClk,
  input  logic                                     ifRst,
  input  logic [NUM_PORTS-1:0][REQ_CMD_WIDTH-1:0]  req_cmd_in,
  input  logic [NUM_PORTS-1:0][REQ_DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_PORTS-1:0][REQ_TAG_WIDTH-1:0]  req_tag_in,
  output logic                                     issue_valid,
  input  logic                                     issue_ready,
  output logic [1:0]                               issue_port,
  output logic [REQ_CMD_WIDTH-1:0]                 issue_cmd,
  output logic [REQ_DATA_WIDTH-1:0]                issue_op1,
  output logic [REQ_DATA_WIDTH-1:0]                issue_op2,
  output logic [REQ_TAG_WIDTH-1:0]                 issue_tag,
  output logic [NUM_PORTS-1:0]                     ovf_pulse
);
  logic [NUM_PORTS-1:0] w_empty, w_pop;
  calc_req_t            w_head [NUM_PORTS];
  calc_req_t            w_sel;
  logic [1:0]           r_ptr, r_lock_port, w_scan, w_idx, w_grant;
  logic                 r_lock, w_found, w_hs;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc_port_fifo #(.DEPTH(FIFO_DEPTH)) u_port (
      .gclk    (ifClk),
      .grst_n  (ifRst),
      .i_cmd   (req_cmd_in[g]),
      .i_data  (req_data_in[g]),
      .i_tag   (req_tag_in[g]),
      .i_pop   (w_pop[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g]),
      .o_ovf   (ovf_pulse[g])
    );
  end

  always_comb begin
    w_found = 1'b0;
    w_scan  = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_scan  = w_idx;
      end
    end
  end

  // a stalled grant stays put so the offered request cannot change under the consumer
  assign w_grant     = r_lock ? r_lock_port : w_scan;
  assign issue_valid = !w_empty[w_grant];
  assign w_hs        = issue_valid && issue_ready;
  assign w_pop       = w_hs ? (NUM_PORTS'(1) << w_grant) : '0;
  assign w_sel       = w_head[w_grant];

  assign issue_port = issue_valid ? w_grant   : '0;
  assign issue_cmd  = issue_valid ? w_sel.cmd : '0;
  assign issue_tag  = issue_valid ? w_sel.tag : '0;
  assign issue_op1  = issue_valid ? w_sel.op1 : '0;
  assign issue_op2  = issue_valid ? w_sel.op2 : '0;

  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lock_port <= '0;
    end else begin
      r_lock      <= issue_valid && !issue_ready;
      r_lock_port <= w_grant;
      if (w_hs) r_ptr <= w_grant + 2'd1;
    end
  end
endmodule
